// File: rtl/shift_win_pkg.sv
// Shared types and elaboration helpers for the shift-window controller.
package shift_win_pkg;

    // Controller states: waiting, window open, post-window holdoff.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        HOLDOFF = 2'd2
    } win_state_t;

    // Narrowest holdoff counter ever built; GAP=0 still gets one bit.
    localparam int HOLD_W_MIN = 1;

    // Holdoff counter width for a given gap: $clog2(GAP+1), at least HOLD_W_MIN.
    function automatic int hold_width(input int gap);
        int w;
        w = $clog2(gap + 1);
        return (w < HOLD_W_MIN) ? HOLD_W_MIN : w;
    endfunction

    // CNT_W must be usable as a shift width; DEF_LEN must be a legal window length.
    function automatic bit cnt_w_ok(input int cnt_w);
        return (cnt_w >= 1) && (cnt_w <= 30);
    endfunction

    function automatic bit def_len_ok(input int cnt_w, input int def_len);
        return cnt_w_ok(cnt_w) && (def_len >= 1) && (def_len <= ((1 << cnt_w) - 1));
    endfunction

endpackage

// File: rtl/win_down_counter.sv
// Saturating down counter with load, decrement and clear; used for both the
// window length and the holdoff gap.
module win_down_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         zero
);

    // Clear wins over load, load over decrement; decrement stops at zero.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/shift_window_gen.sv
// Start-triggered shift_en window generator with programmable length,
// optional retrigger, abort, post-window holdoff, done and dropped-start pulses.
module shift_window_gen
    import shift_win_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int DEF_LEN = 16,
    parameter int GAP     = 0,
    parameter int RETRIG  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             abort,
    output logic             shift_en,
    output logic             busy,
    output logic             done,
    output logic             start_drop,
    output logic [CNT_W-1:0] remaining
);

    localparam int                HOLD_W    = hold_width(GAP);
    localparam logic [CNT_W-1:0]  DEF_LEN_C = CNT_W'(DEF_LEN);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = (GAP > 0) ? HOLD_W'(GAP - 1) : '0;
    localparam bit                HAS_GAP   = (GAP > 0);
    localparam bit                CAN_RETRIG = (RETRIG != 0);

    if (!cnt_w_ok(CNT_W)) begin : g_bad_cnt_w
        $error("shift_window_gen: CNT_W must be in 1..30");
    end
    if (!def_len_ok(CNT_W, DEF_LEN)) begin : g_bad_def_len
        $error("shift_window_gen: DEF_LEN must be in 1..2^CNT_W-1");
    end

    // Counter preload for a new window: length minus the cycle about to be spent.
    function automatic logic [CNT_W-1:0] load_value(input logic [CNT_W-1:0] l);
        logic [CNT_W-1:0] eff;
        eff = (l == '0) ? DEF_LEN_C : l;
        return eff - CNT_W'(1);
    endfunction

    win_state_t        state;
    win_state_t        state_nxt;
    logic              win_load;
    logic              win_dec;
    logic              win_clr;
    logic              win_zero;
    logic              hold_load;
    logic              hold_dec;
    logic              hold_clr;
    logic              hold_zero;
    logic [HOLD_W-1:0] hold_count;
    logic              done_nxt;
    logic              drop_nxt;

    win_down_counter #(.W(CNT_W)) u_win_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (win_load),
        .load_val (load_value(len)),
        .dec      (win_dec),
        .clr      (win_clr),
        .count    (remaining),
        .zero     (win_zero)
    );

    win_down_counter #(.W(HOLD_W)) u_hold_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (hold_load),
        .load_val (HOLD_LOAD),
        .dec      (hold_dec),
        .clr      (hold_clr),
        .count    (hold_count),
        .zero     (hold_zero)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, counter controls and pulse decisions; abort beats start.
    always_comb begin
        state_nxt = state;
        win_load  = 1'b0;
        win_dec   = 1'b0;
        win_clr   = 1'b0;
        hold_load = 1'b0;
        hold_dec  = 1'b0;
        hold_clr  = 1'b0;
        done_nxt  = 1'b0;
        drop_nxt  = start;
        unique case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_nxt = ACTIVE;
                    win_load  = 1'b1;
                    drop_nxt  = 1'b0;
                end
            end
            ACTIVE: begin
                if (abort) begin
                    win_clr   = 1'b1;
                    hold_load = HAS_GAP;
                    state_nxt = HAS_GAP ? HOLDOFF : IDLE;
                end else if (start && CAN_RETRIG) begin
                    win_load = 1'b1;
                    drop_nxt = 1'b0;
                end else if (win_zero) begin
                    done_nxt  = 1'b1;
                    hold_load = HAS_GAP;
                    state_nxt = HAS_GAP ? HOLDOFF : IDLE;
                end else begin
                    win_dec = 1'b1;
                end
            end
            HOLDOFF: begin
                if (abort) begin
                    hold_clr  = 1'b1;
                    state_nxt = IDLE;
                end else if (hold_zero) begin
                    state_nxt = IDLE;
                end else begin
                    hold_dec = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Registered outputs, all derived from the upcoming state so they align with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_en   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            start_drop <= 1'b0;
        end else begin
            shift_en   <= (state_nxt == ACTIVE);
            busy       <= (state_nxt != IDLE);
            done       <= done_nxt;
            start_drop <= drop_nxt;
        end
    end

endmodule

// File: tb/tb_shift_window_gen.sv
// Scoreboard bench: three controller configurations share one stimulus stream;
// a behavioural model queues expected outputs per cycle.
module tb_shift_window_gen;

    typedef struct packed {
        logic       se;
        logic       bs;
        logic       dn;
        logic       sd;
        logic [7:0] rem;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] len = 8'd0;
    logic       abort = 1'b0;

    logic       se [3];
    logic       bs [3];
    logic       dn [3];
    logic       sd [3];
    logic [7:0] rem [3];

    int   n_vec = 0;
    int   n_err = 0;
    int   shift_cnt = 0;
    exp_t sb [$];

    // Model state: 0 idle, 1 active, 2 holdoff; hold counts holdoff cycles left incl. current.
    int m_st [3]   = '{0, 0, 0};
    int m_rem [3]  = '{0, 0, 0};
    int m_hold [3] = '{0, 0, 0};
    int gap_c [3]  = '{0, 3, 0};
    int rt_c [3]   = '{0, 0, 1};

    always #5 clk = ~clk;

    shift_window_gen #(.CNT_W(8), .DEF_LEN(16), .GAP(0), .RETRIG(0)) u_g0 (
        .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort),
        .shift_en(se[0]), .busy(bs[0]), .done(dn[0]), .start_drop(sd[0]), .remaining(rem[0])
    );
    shift_window_gen #(.CNT_W(8), .DEF_LEN(16), .GAP(3), .RETRIG(0)) u_g3 (
        .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort),
        .shift_en(se[1]), .busy(bs[1]), .done(dn[1]), .start_drop(sd[1]), .remaining(rem[1])
    );
    shift_window_gen #(.CNT_W(8), .DEF_LEN(16), .GAP(0), .RETRIG(1)) u_rt (
        .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort),
        .shift_en(se[2]), .busy(bs[2]), .done(dn[2]), .start_drop(sd[2]), .remaining(rem[2])
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d at %0t", tag, got, want, $time);
        end
    endtask

    task automatic model_step(input int i, output exp_t e);
        int  eff;
        logic dn_e;
        logic sd_e;
        eff  = (len == 8'd0) ? 16 : int'(len);
        dn_e = 1'b0;
        sd_e = 1'b0;
        if (rst) begin
            m_st[i] = 0; m_rem[i] = 0; m_hold[i] = 0;
        end else if (m_st[i] == 0) begin
            if (start && !abort) begin
                m_st[i] = 1; m_rem[i] = eff - 1;
            end else begin
                sd_e = start;
            end
        end else if (m_st[i] == 1) begin
            if (abort) begin
                sd_e = start; m_rem[i] = 0;
                m_st[i] = (gap_c[i] > 0) ? 2 : 0; m_hold[i] = gap_c[i];
            end else if (start && rt_c[i] != 0) begin
                m_rem[i] = eff - 1;
            end else begin
                sd_e = start;
                if (m_rem[i] == 0) begin
                    dn_e = 1'b1;
                    m_st[i] = (gap_c[i] > 0) ? 2 : 0; m_hold[i] = gap_c[i];
                end else begin
                    m_rem[i] = m_rem[i] - 1;
                end
            end
        end else begin
            sd_e = start;
            if (abort) begin
                m_st[i] = 0;
            end else begin
                m_hold[i] = m_hold[i] - 1;
                if (m_hold[i] == 0) m_st[i] = 0;
            end
        end
        e.se  = (m_st[i] == 1);
        e.bs  = (m_st[i] != 0);
        e.dn  = dn_e;
        e.sd  = sd_e;
        e.rem = 8'(m_rem[i]);
    endtask

    task automatic step();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            model_step(i, e);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            e = sb.pop_front();
            chk_eq($sformatf("u%0d.shift_en", i),   32'(se[i]),  32'(e.se));
            chk_eq($sformatf("u%0d.busy", i),       32'(bs[i]),  32'(e.bs));
            chk_eq($sformatf("u%0d.done", i),       32'(dn[i]),  32'(e.dn));
            chk_eq($sformatf("u%0d.start_drop", i), 32'(sd[i]),  32'(e.sd));
            chk_eq($sformatf("u%0d.remaining", i),  32'(rem[i]), 32'(e.rem));
            chk_eq($sformatf("u%0d.done_and_shift", i), 32'(dn[i] & se[i]), 32'd0);
        end
        if (se[0]) shift_cnt++;
    endtask

    task automatic apply(input logic s, input logic [7:0] l, input logic a, input logic r);
        start = s; len = l; abort = a; rst = r;
        step();
        start = 1'b0; abort = 1'b0; rst = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) apply(1'b0, len, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // reset state
        apply(1'b0, 8'd0, 1'b0, 1'b1);
        apply(1'b0, 8'd0, 1'b0, 1'b1);
        idle(3);

        // basic 16-cycle window
        shift_cnt = 0;
        apply(1'b1, 8'd16, 1'b0, 1'b0);
        idle(25);
        chk_eq("t1_window_len", 32'(shift_cnt), 32'd16);

        // len=0 selects DEF_LEN, len=1 is a single-cycle window
        shift_cnt = 0;
        apply(1'b1, 8'd0, 1'b0, 1'b0);
        idle(20);
        chk_eq("t2_def_len", 32'(shift_cnt), 32'd16);
        shift_cnt = 0;
        apply(1'b1, 8'd1, 1'b0, 1'b0);
        idle(4);
        chk_eq("t2_len1", 32'(shift_cnt), 32'd1);

        // holdoff: starts at 6 and 7 land in holdoff, start at 8 accepted
        apply(1'b1, 8'd4, 1'b0, 1'b0);
        idle(5);
        apply(1'b1, 8'd4, 1'b0, 1'b0);
        apply(1'b1, 8'd4, 1'b0, 1'b0);
        apply(1'b1, 8'd4, 1'b0, 1'b0);
        idle(20);

        // retrigger vs dropped start
        apply(1'b1, 8'd8, 1'b0, 1'b0);
        idle(3);
        apply(1'b1, 8'd5, 1'b0, 1'b0);
        idle(15);

        // retrigger on the last active cycle
        apply(1'b1, 8'd3, 1'b0, 1'b0);
        idle(2);
        apply(1'b1, 8'd2, 1'b0, 1'b0);
        idle(8);

        // abort together with start
        apply(1'b1, 8'd10, 1'b0, 1'b0);
        idle(4);
        apply(1'b1, 8'd10, 1'b1, 1'b0);
        idle(10);

        // abort during holdoff and abort while idle
        apply(1'b1, 8'd2, 1'b0, 1'b0);
        idle(3);
        apply(1'b0, 8'd0, 1'b1, 1'b0);
        apply(1'b0, 8'd0, 1'b1, 1'b0);
        idle(5);

        // reset mid-window, then start right away; reset mid-holdoff
        apply(1'b1, 8'd10, 1'b0, 1'b0);
        idle(4);
        apply(1'b0, 8'd0, 1'b0, 1'b1);
        apply(1'b1, 8'd3, 1'b0, 1'b0);
        idle(10);
        apply(1'b1, 8'd2, 1'b0, 1'b0);
        idle(3);
        apply(1'b0, 8'd0, 1'b0, 1'b1);
        idle(8);

        // max length window
        apply(1'b1, 8'd255, 1'b0, 1'b0);
        idle(260);

        // random traffic
        for (int k = 0; k < 600; k++) begin
            apply($urandom_range(0, 3) == 0,
                  8'($urandom_range(0, 12)),
                  $urandom_range(0, 15) == 0,
                  $urandom_range(0, 63) == 0);
        end
        idle(30);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
